// File: rtl/cic_integ_decim_if.sv
// Sample stream into and decimated stream out of the CIC integrator/decimator.
// The master side drives samples in; the slave side is the filter itself.
interface cic_integ_decim_if #(
  parameter int unsigned Win  = 16,
  parameter int unsigned Wout = 25
);
  logic                   val_in;
  logic signed [Win-1:0]  data_in;
  logic                   val_out;
  logic signed [Wout-1:0] data_out;

  modport master (output val_in, data_in, input val_out, data_out);
  modport slave  (input val_in, data_in, output val_out, data_out);
endinterface

// File: rtl/cic_integ_decim.sv
// N-stage pipelined integrator chain followed by a decimate-by-R output register.
// All sums wrap modulo 2^Wout; the downstream comb cascade cancels the wrap.
module cic_integ_decim #(
  parameter int unsigned Win  = 16,
  parameter int unsigned N    = 3,
  parameter int unsigned R    = 8,
  parameter int unsigned Wout = 25
) (
  input  logic                clk,
  input  logic                rst,
  cic_integ_decim_if.slave    bus
);

  localparam int unsigned CW = (R > 1) ? $clog2(R) : 1;

  logic [Wout-1:0] acc_q [N];
  logic [Wout-1:0] acc_d [N];
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            val_out_q, val_out_d;
  logic [Wout-1:0] data_out_q, data_out_d;
  logic [Wout-1:0] ext_c;

  assign ext_c = {{(Wout-Win){bus.data_in[Win-1]}}, bus.data_in};

  // Each stage adds the previous stage's registered value, giving one sample of delay per stage.
  always_comb begin
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    val_out_d  = 1'b0;
    data_out_d = data_out_q;
    if (bus.val_in) begin
      acc_d[0] = acc_q[0] + ext_c;
      for (int i = 1; i < int'(N); i++) begin
        acc_d[i] = acc_q[i] + acc_q[i-1];
      end
      if (cnt_q == CW'(R - 1)) begin
        cnt_d      = '0;
        val_out_d  = 1'b1;
        data_out_d = acc_d[N-1];
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(N); i++) begin
        acc_q[i] <= '0;
      end
      cnt_q      <= '0;
      val_out_q  <= 1'b0;
      data_out_q <= '0;
    end else begin
      for (int i = 0; i < int'(N); i++) begin
        acc_q[i] <= acc_d[i];
      end
      cnt_q      <= cnt_d;
      val_out_q  <= val_out_d;
      data_out_q <= data_out_d;
    end
  end

  assign bus.val_out  = val_out_q;
  assign bus.data_out = data_out_q;

endmodule

// File: tb/tb_cic_integ_decim.sv
// Scoreboard bench for cic_integ_decim: binomial-weighted history model,
// decoupled monitor, directed phases followed by randomized traffic.
module tb_cic_integ_decim;

  localparam int unsigned WIN  = 16;
  localparam int unsigned NST  = 3;
  localparam int unsigned RDEC = 8;
  localparam int unsigned WOUT = 25;

  typedef struct {
    int              cyc;
    logic [WOUT-1:0] data;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  bit   mon_en;
  int   n_vec;
  int   n_err;

  exp_t            exp_q[$];
  int              hist[$];
  logic [WOUT-1:0] obs[$];

  cic_integ_decim_if #(.Win(WIN), .Wout(WOUT)) bus ();

  cic_integ_decim #(.Win(WIN), .N(NST), .R(RDEC), .Wout(WOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic longint binom(input int d, input int k);
    longint r;
    if (d < k) return 0;
    r = 1;
    for (int i = 0; i < k; i++) r = r * longint'(d - i) / longint'(i + 1);
    return r;
  endfunction

  // Output of an N-stage pipelined integrator after n samples: sum x_j * C(n-j, N-1).
  function automatic logic [WOUT-1:0] model_out();
    longint s;
    int     n;
    s = 0;
    n = hist.size();
    for (int j = 0; j < n; j++) s += longint'(hist[j]) * binom(n - 1 - j, int'(NST) - 1);
    return WOUT'(s);
  endfunction

  task automatic step(input bit r, input bit v, input int d);
    exp_t e;
    rst         = r;
    bus.val_in  = v;
    bus.data_in = WIN'(d);
    if (r) begin
      hist.delete();
    end else if (v) begin
      hist.push_back(d);
      if (hist.size() % int'(RDEC) == 0) begin
        e.cyc  = cyc + 1;
        e.data = model_out();
        exp_q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    if (r) begin
      mon_en = 1'b1;
      n_vec++;
      if (bus.data_out !== '0 || bus.val_out !== 1'b0) begin
        n_err++;
        $display("FAIL reset_out cyc=%0d data_out=%0d val_out=%b want 0/0",
                 cyc, bus.data_out, bus.val_out);
      end
    end
  endtask

  // Monitor: pops the scoreboard whenever an output is due, otherwise demands silence.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        e = exp_q.pop_front();
        n_vec++;
        n_err++;
        $display("FAIL missed_out due_cyc=%0d want data_out=%0d", e.cyc, $signed(e.data));
      end
      n_vec++;
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        e = exp_q.pop_front();
        if (bus.val_out !== 1'b1 || bus.data_out !== e.data) begin
          n_err++;
          $display("FAIL dec_out cyc=%0d val_out=%b data_out=%0d want 1/%0d",
                   cyc, bus.val_out, bus.data_out, $signed(e.data));
        end
        obs.push_back(bus.data_out);
      end else if (bus.val_out !== 1'b0) begin
        n_err++;
        $display("FAIL spurious_val cyc=%0d val_out=%b want 0", cyc, bus.val_out);
      end
    end
  end

  initial begin
    logic [WOUT-1:0] c1[$];
    logic [WOUT-1:0] c2[$];
    logic [WOUT-1:0] c3[$];
    logic [WOUT-1:0] want_dc;
    n_vec       = 0;
    n_err       = 0;
    mon_en      = 1'b0;
    rst         = 1'b1;
    bus.val_in  = 1'b0;
    bus.data_in = '0;
    @(posedge clk);
    #1;

    // Reset dominates a valid input
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1234);

    // Step: 56, 560, 2024
    for (int i = 0; i < 24; i++) step(1'b0, 1'b1, 1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 0);

    // Gapped step: same values, outputs 16 clocks apart
    step(1'b1, 1'b0, 0);
    for (int i = 0; i < 48; i++) step(1'b0, (i % 2) == 0, 1);

    // Reset mid-frame after sample 5
    step(1'b1, 1'b0, 0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1);
    step(1'b1, 1'b1, 1);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 1);

    // Negative input: -56, -560
    step(1'b1, 1'b0, 0);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, -1);

    // Full-scale positive: wraps the accumulators
    step(1'b1, 1'b0, 0);
    step(1'b0, 1'b0, 0);
    obs.delete();
    for (int i = 0; i < 64; i++) step(1'b0, 1'b1, 32767);
    step(1'b0, 1'b0, 0);
    step(1'b0, 1'b0, 0);

    // Three comb stages over the decimated stream must settle to x*R^N
    want_dc = WOUT'(longint'(32767) * 512);
    for (int k = 0; k < obs.size(); k++) begin
      c1.push_back(obs[k] - ((k > 0) ? obs[k-1] : '0));
      c2.push_back(c1[k]  - ((k > 0) ? c1[k-1]  : '0));
      c3.push_back(c2[k]  - ((k > 0) ? c2[k-1]  : '0));
    end
    n_vec++;
    if (obs.size() != 8) begin
      n_err++;
      $display("FAIL wrap_count got %0d outputs want 8", obs.size());
    end
    for (int k = 2; k < obs.size(); k++) begin
      n_vec++;
      if (c3[k] !== want_dc) begin
        n_err++;
        $display("FAIL comb_dc idx=%0d got %0d want %0d", k, $signed(c3[k]), $signed(want_dc));
      end
    end

    // Randomized traffic with gaps and occasional resets
    step(1'b1, 1'b0, 0);
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, int'($signed(WIN'($urandom))));
    end
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 0);

    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain pending=%0d want 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cic_integ_decim.md
# cic_integ_decim

Integrator-and-decimator front end of the CIC decimation filter. It accumulates every valid input sample through an N-stage pipelined integrator chain, then emits one full-width sample every R valid inputs. It sits directly upstream of the comb cascade: its val_out/data_out drive the first COMB stage's val_in/data_in.

## Interface
- Win, 16, input sample width (signed two's complement)
- N, 3, number of integrator stages (1..6)
- R, 8, decimation factor (2..256)
- Wout, 25, accumulator and output width; must equal Win + N*ceil(log2(R))
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  reset, synchronous, active-high
- val_in  input  1  qualifies data_in for the current cycle
- data_in  input  Win  signed input sample
- val_out  output  1  one-cycle strobe, data_out valid
- data_out  output  Wout  signed decimated integrator output

## Operation
- Reset, synchronous active-high: acc[1..N] = 0, decimation counter cnt = 0, data_out = 0, val_out = 0. Reset has priority over val_in in the same cycle.
- Integrators update only on cycles with val_in=1; with val_in=0, all accumulators and cnt hold.
- Stage 1: acc1 <= acc1 + sign_extend(data_in, Wout).
- Stage i, 2..N: acc_i <= acc_i + acc_(i-1). Uses the registered value of acc_(i-1) from before this edge, so each stage adds one sample of pipeline delay.
- All arithmetic is Wout-bit two's complement with silent wrap-around, no saturation. Wrap is intentional: the comb stages cancel it, given the Wout rule.
- Decimation counter cnt counts valid inputs 0..R-1 and increments on each val_in.
  - On val_in with cnt == R-1: cnt <= 0, data_out <= the new acc_N value (acc_N + acc_(N-1)), val_out <= 1.
  - Otherwise val_out <= 0, and data_out holds its last value.
- No backpressure: downstream must accept every val_out strobe.
- Output phase is fixed by reset. The first output follows the R-th valid sample after reset deasserts.

## Timing
- Latency: val_out rises on the clock edge that samples the R-th (2R-th, ...) val_in, i.e. one clock after that sample is presented.
- val_out is high for exactly one cycle per R valid inputs. It is never high on two consecutive cycles when R >= 2.
- Gaps in val_in stretch the output period but do not change values; the output depends only on the sequence of valid samples.
- Reset mid-operation discards partial sums and the counter phase. The next val_out comes R valid samples after rst falls.
- Throughput: one input per clock, sustained.

## Test plan
- Reset: hold rst 3 cycles with val_in=1, data_in=1234 -> data_out=0, val_out=0 throughout; accumulators stay 0.
- Step response, N=3, R=8: data_in=1 on every cycle after reset.
  - Expect val_out on samples 8, 16, 24 with data_out = 56, 560, 2024 (C(k,3)).
  - Expect val_out=0 on all other cycles.
- Gapped valid: repeat the step test with val_in toggling 1,0,1,0 -> same data_out sequence 56, 560, 2024; val_out spaced 16 clocks apart.
- Wrap-around: data_in = 32767 continuously for 64 samples -> every data_out equals a bit-exact mod-2^25 model of the pipelined chain.
  - Cascade into 3 COMB stages: after settling, the comb output equals 32767*512 mod 2^Wout, interpreted as signed.
- Reset mid-frame: apply the step, assert rst for 1 cycle after sample 5, then resume the step -> first val_out at the 8th post-reset sample, data_out=56.
- Negative input: data_in = -1 continuously -> data_out = -56, -560; sign extension verified.
